piso_serializer: RTL and testbench

- Parallel-in/serial-out converter; the read-out end of a parallel data register.
- Accepts a DATA_WIDTH word on a valid/ready load handshake.
- Emits the word one bit per accepted serial beat, under valid/ready backpressure, with first/last markers and a completion pulse.
- Sits between register-held parallel data and a bit-serial consumer (LED/shift chain, serial link).

---
 rtl/piso_serializer.sv | 106 ++++++++++
 tb/tb_piso_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out converter with valid/ready on both sides.
// Define PISO_MSB_FIRST_EN to emit MSB first; LSB first otherwise.
module piso_serializer #(
   parameter  int DATA_WIDTH = 8,
   localparam int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  Clk,
   input  logic                  reset,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic                  serial_ready,
   output logic                  serial_valid,
   output logic                  serial_out,
   output logic                  serial_first,
   output logic                  serial_last,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

   state_t                state;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [CNT_WIDTH-1:0]  bit_cnt;
   logic                  load_fire;
   logic                  beat_fire;
   logic                  at_last;
   logic                  head_bit;

`ifdef PISO_MSB_FIRST_EN
   assign head_bit = shift_reg[DATA_WIDTH-1];
`else
   assign head_bit = shift_reg[0];
`endif

   assign at_last = (bit_cnt == LAST_CNT);

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Every output is a decode of state/shift_reg/bit_cnt; load_ready also masks reset.
   always_comb begin
      state_next   = state;
      load_ready   = 1'b0;
      serial_valid = 1'b0;
      serial_out   = 1'b0;
      serial_first = 1'b0;
      serial_last  = 1'b0;
      done         = 1'b0;
      load_fire    = 1'b0;
      beat_fire    = 1'b0;
      case (state)
         IDLE: begin
            load_ready = !reset;
            if (load_valid && !reset) begin
               load_fire  = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            serial_valid = 1'b1;
            serial_out   = head_bit;
            serial_first = (bit_cnt == '0);
            serial_last  = at_last;
            if (serial_ready) begin
               beat_fire = 1'b1;
               if (at_last) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (load_fire) begin
         shift_reg <= D;
         bit_cnt   <= '0;
      end else if (beat_fire) begin
`ifdef PISO_MSB_FIRST_EN
         shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
`else
         shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
`endif
         // Counter returns to 0 after the final beat instead of wrapping past the last index.
         bit_cnt <= at_last ? '0 : bit_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized scoreboard bench for piso_serializer.
module tb_piso_serializer;
   localparam int W = 8;

   logic         Clk = 1'b0;
   logic         reset = 1'b0;
   logic         load_valid = 1'b0;
   logic         load_ready;
   logic [W-1:0] D = '0;
   logic         serial_ready = 1'b1;
   logic         serial_valid;
   logic         serial_out;
   logic         serial_first;
   logic         serial_last;
   logic         done;

   typedef struct {
      logic b;
      logic f;
      logic l;
   } beat_t;

   beat_t q[$];
   logic  expect_done = 1'b0;
   logic  rnd_ready = 1'b0;
   int    total = 0;
   int    bad = 0;

   piso_serializer #(.DATA_WIDTH(W)) dut (
      .Clk(Clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .D(D), .serial_ready(serial_ready), .serial_valid(serial_valid),
      .serial_out(serial_out), .serial_first(serial_first), .serial_last(serial_last),
      .done(done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic ref_bit(input logic [W-1:0] w, input int i);
`ifdef PISO_MSB_FIRST_EN
      return w[W-1-i];
`else
      return w[i];
`endif
   endfunction

   // Reference model: an accepted word becomes W queued beats; done follows the last beat.
   always @(negedge Clk) begin
      if (reset) begin
         chk("rst_load_ready", int'(load_ready), 0);
         chk("rst_valid", int'(serial_valid), 0);
         chk("rst_out", int'(serial_out), 0);
         chk("rst_done", int'(done), 0);
         q.delete();
         expect_done = 1'b0;
      end else begin
         logic idle;
         logic nd;
         beat_t b;
         idle = (q.size() == 0) && !expect_done;
         nd = 1'b0;
         chk("done", int'(done), int'(expect_done));
         chk("load_ready", int'(load_ready), int'(idle));
         chk("serial_valid", int'(serial_valid), int'(q.size() != 0));
         if (q.size() != 0) begin
            chk("serial_out", int'(serial_out), int'(q[0].b));
            chk("serial_first", int'(serial_first), int'(q[0].f));
            chk("serial_last", int'(serial_last), int'(q[0].l));
            if (serial_ready) begin
               b = q.pop_front();
               nd = b.l;
            end
         end else begin
            chk("idle_out", int'(serial_out), 0);
            chk("idle_first", int'(serial_first), 0);
            chk("idle_last", int'(serial_last), 0);
         end
         if (idle && load_valid) begin
            for (int i = 0; i < W; i++) begin
               b.b = ref_bit(D, i);
               b.f = (i == 0);
               b.l = (i == W - 1);
               q.push_back(b);
            end
         end
         expect_done = nd;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
      if (rnd_ready) serial_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [W-1:0] w);
      int n;
      n = 0;
      load_valid = 1'b1;
      D = w;
      while (!load_ready && n < 200) begin
         tick();
         n++;
      end
      chk("load_timeout", int'(n >= 200), 0);
      tick();
      load_valid = 1'b0;
      D = W'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || expect_done) && n < 500) begin
         tick();
         n++;
      end
      tick();
      chk("drain_timeout", int'(n >= 500), 0);
   endtask

   task automatic async_reset_check();
      #2 reset = 1'b1;
      #1;
      chk("async_load_ready", int'(load_ready), 0);
      chk("async_valid", int'(serial_valid), 0);
      chk("async_out", int'(serial_out), 0);
      chk("async_first", int'(serial_first), 0);
      chk("async_last", int'(serial_last), 0);
      chk("async_done", int'(done), 0);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #3 reset = 1'b1;
      #1;
      chk("init_load_ready", int'(load_ready), 0);
      chk("init_valid", int'(serial_valid), 0);
      chk("init_done", int'(done), 0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      send(8'hA5);
      drain();

      send(8'h3C);
      tick();
      serial_ready = 1'b0;
      tick();
      tick();
      tick();
      serial_ready = 1'b1;
      drain();

      send(8'hFF);
      tick();
      load_valid = 1'b1;
      D = 8'h00;
      tick();
      load_valid = 1'b0;
      drain();
      send(8'h00);
      drain();

      send(8'hF0);
      tick();
      tick();
      tick();
      async_reset_check();
      tick();
      send(8'h81);
      drain();

      send(8'h01);
      drain();

      rnd_ready = 1'b1;
      for (int k = 0; k < 150; k++) begin
         send(W'($urandom));
         if ($urandom_range(0, 4) == 0) drain();
      end
      drain();
      rnd_ready = 1'b0;
      serial_ready = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
